// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU arbiter: select codes, FSM encoding and default widths.
package alu_ctrl_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int SEL_WIDTH_DEF  = 3;

  localparam logic [2:0] SEL_FORWARD = 3'b000;
  localparam logic [2:0] SEL_ADD     = 3'b001;
  localparam logic [2:0] SEL_AND     = 3'b010;
  localparam logic [2:0] SEL_OR      = 3'b011;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Any select with the top bit set has no ALU meaning and is rejected without execution
  function automatic logic op_legal(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the requester not served last.
module rr_arbiter2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic grant_valid,
  output logic gid
);

  // Grant selection
  always_comb begin
    grant_valid = req0 | req1;
    gid         = 1'b0;
    if (req0 && req1) begin
      gid = ~last;
    end else if (req1) begin
      gid = 1'b1;
    end else begin
      gid = 1'b0;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters with round-robin arbitration,
// operand hold for EXEC_CYCLES and per-requester result registers.
module alu_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int SEL_WIDTH   = SEL_WIDTH_DEF,
  parameter int EXEC_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic [SEL_WIDTH-1:0]  op0,
  input  logic [DATA_WIDTH-1:0] a0,
  input  logic [DATA_WIDTH-1:0] b0,
  output logic                  done0,
  output logic [DATA_WIDTH-1:0] result0,
  input  logic                  req1,
  input  logic [SEL_WIDTH-1:0]  op1,
  input  logic [DATA_WIDTH-1:0] a1,
  input  logic [DATA_WIDTH-1:0] b1,
  output logic                  done1,
  output logic [DATA_WIDTH-1:0] result1,
  output logic [DATA_WIDTH-1:0] alu_data1,
  output logic [DATA_WIDTH-1:0] alu_data2,
  output logic [SEL_WIDTH-1:0]  alu_select,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic                  busy,
  output logic                  err
);

  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  logic [1:0]            state_r;
  logic [3:0]            cnt_r;
  logic                  last_r;
  logic                  gid_r;
  logic                  done0_r, done1_r, err_r, busy_r;
  logic [DATA_WIDTH-1:0] result0_r, result1_r;
  logic [DATA_WIDTH-1:0] alu_data1_r, alu_data2_r;
  logic [SEL_WIDTH-1:0]  alu_select_r;

  logic                  grant_valid_s;
  logic                  grant_gid_s;
  logic [SEL_WIDTH-1:0]  grant_op_s;
  logic [DATA_WIDTH-1:0] grant_a_s, grant_b_s;

  rr_arbiter2 u_rr (
    .req0        (req0),
    .req1        (req1),
    .last        (last_r),
    .grant_valid (grant_valid_s),
    .gid         (grant_gid_s)
  );

  // Operand mux for the requester being granted this cycle
  always_comb begin
    if (grant_gid_s) begin
      grant_op_s = op1;
      grant_a_s  = a1;
      grant_b_s  = b1;
    end else begin
      grant_op_s = op0;
      grant_a_s  = a0;
      grant_b_s  = b0;
    end
  end

  // Arbitration FSM; ALU port registers double as the latched operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 4'd0;
      last_r       <= 1'b1;
      gid_r        <= 1'b0;
      done0_r      <= 1'b0;
      done1_r      <= 1'b0;
      err_r        <= 1'b0;
      busy_r       <= 1'b0;
      result0_r    <= '0;
      result1_r    <= '0;
      alu_data1_r  <= '0;
      alu_data2_r  <= '0;
      alu_select_r <= '0;
    end else begin
      done0_r <= 1'b0;
      done1_r <= 1'b0;
      err_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (grant_valid_s) begin
            gid_r  <= grant_gid_s;
            busy_r <= 1'b1;
            if (op_legal(grant_op_s[2:0])) begin
              alu_data1_r  <= grant_a_s;
              alu_data2_r  <= grant_b_s;
              alu_select_r <= grant_op_s;
              cnt_r        <= CNT_INIT;
              state_r      <= ST_EXEC;
            end else begin
              // Illegal select bypasses the ALU: zero result, complete with error next cycle
              if (grant_gid_s) begin
                result1_r <= '0;
              end else begin
                result0_r <= '0;
              end
              done0_r <= ~grant_gid_s;
              done1_r <= grant_gid_s;
              err_r   <= 1'b1;
              state_r <= ST_DONE;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_EXEC: begin
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            if (gid_r) begin
              result1_r <= alu_result;
            end else begin
              result0_r <= alu_result;
            end
            done0_r <= ~gid_r;
            done1_r <= gid_r;
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          last_r       <= gid_r;
          busy_r       <= 1'b0;
          alu_data1_r  <= '0;
          alu_data2_r  <= '0;
          alu_select_r <= '0;
          state_r      <= ST_IDLE;
        end
        default: begin
          busy_r       <= 1'b0;
          alu_data1_r  <= '0;
          alu_data2_r  <= '0;
          alu_select_r <= '0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

  assign done0      = done0_r;
  assign done1      = done1_r;
  assign err        = err_r;
  assign busy       = busy_r;
  assign result0    = result0_r;
  assign result1    = result1_r;
  assign alu_data1  = alu_data1_r;
  assign alu_data2  = alu_data2_r;
  assign alu_select = alu_select_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: one instance with EXEC_CYCLES=1, one with EXEC_CYCLES=3.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  // EXEC_CYCLES=1 instance
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [2:0] op0 = 3'd0, op1 = 3'd0;
  logic [7:0] a0 = 8'd0, b0 = 8'd0, a1 = 8'd0, b1 = 8'd0;
  logic       done0, done1, busy, err;
  logic [7:0] result0, result1, alu_data1, alu_data2, alu_result;
  logic [2:0] alu_select;

  // EXEC_CYCLES=3 instance
  logic       r3_req0 = 1'b0, r3_req1 = 1'b0;
  logic [2:0] r3_op0 = 3'd0, r3_op1 = 3'd0;
  logic [7:0] r3_a0 = 8'd0, r3_b0 = 8'd0, r3_a1 = 8'd0, r3_b1 = 8'd0;
  logic       d3_done0, d3_done1, d3_busy, d3_err;
  logic [7:0] d3_result0, d3_result1, d3_alu_data1, d3_alu_data2, d3_alu_result;
  logic [2:0] d3_alu_select;

  int total = 0;
  int bad = 0;
  logic [7:0] model_r0 = 8'd0, model_r1 = 8'd0;

  typedef struct {
    bit         gid;
    logic [7:0] res;
    bit         err;
    logic [2:0] sel;
    int         lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [2:0] s, input logic [7:0] x, input logic [7:0] y);
    case (s)
      3'b000:  return y;
      3'b001:  return x + y;
      3'b010:  return x & y;
      3'b011:  return x | y;
      default: return 8'd0;
    endcase
  endfunction

  assign alu_result    = alu_f(alu_select, alu_data1, alu_data2);
  assign d3_alu_result = alu_f(d3_alu_select, d3_alu_data1, d3_alu_data2);

  alu_arbiter #(.DATA_WIDTH(8), .SEL_WIDTH(3), .EXEC_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0), .done0(done0), .result0(result0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1), .done1(done1), .result1(result1),
    .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_select(alu_select),
    .alu_result(alu_result), .busy(busy), .err(err)
  );

  alu_arbiter #(.DATA_WIDTH(8), .SEL_WIDTH(3), .EXEC_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .req0(r3_req0), .op0(r3_op0), .a0(r3_a0), .b0(r3_b0), .done0(d3_done0), .result0(d3_result0),
    .req1(r3_req1), .op1(r3_op1), .a1(r3_a1), .b1(r3_b1), .done1(d3_done1), .result1(d3_result1),
    .alu_data1(d3_alu_data1), .alu_data2(d3_alu_data2), .alu_select(d3_alu_select),
    .alu_result(d3_alu_result), .busy(d3_busy), .err(d3_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit g, input logic [7:0] r, input bit e, input logic [2:0] s, input int l);
    exp_t x;
    x.gid = g; x.res = r; x.err = e; x.sel = s; x.lat = l;
    sb.push_back(x);
  endtask

  // Wait (bounded) for the next completion on the EXEC_CYCLES=1 instance and score it
  task automatic wait_done();
    exp_t e;
    int   n;
    bit   seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (done0 || done1) seen = 1'b1;
    end
    chk("done_seen", 32'(seen), 32'd1);
    if (seen && sb.size() > 0) begin
      e = sb.pop_front();
      if (e.gid) model_r1 = e.res;
      else       model_r0 = e.res;
      chk("done_latency", n, e.lat);
      chk("done_gid", 32'(done1), 32'(e.gid));
      chk("one_done", 32'(done0 & done1), 32'd0);
      chk("err", 32'(err), 32'(e.err));
      chk("busy_in_done", 32'(busy), 32'd1);
      chk("alu_select_hold", 32'(alu_select), 32'(e.sel));
      chk("result0", 32'(result0), 32'(model_r0));
      chk("result1", 32'(result1), 32'(model_r1));
      if (e.gid) req1 = 1'b0;
      else       req0 = 1'b0;
    end
  endtask

  task automatic single(input bit g, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] res, input bit e);
    @(negedge clk);
    if (g) begin op1 = op; a1 = a; b1 = b; req1 = 1'b1; end
    else   begin op0 = op; a0 = a; b0 = b; req0 = 1'b1; end
    push(g, res, e, e ? 3'b000 : op, e ? 1 : 2);
    wait_done();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'({done0, done1, err}), 32'd0);
    chk("rst_result0", 32'(result0), 32'd0);
    chk("rst_result1", 32'(result1), 32'd0);
    chk("rst_alu_ports", 32'({alu_data1, alu_data2, alu_select}), 32'd0);
    rst_n = 1'b1;

    // Long-latency instance: ports held for 3 cycles, request dropped mid-EXEC
    @(negedge clk);
    r3_op0 = 3'b001; r3_a0 = 8'd10; r3_b0 = 8'd20; r3_req0 = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("x3_sel", 32'(d3_alu_select), 32'd1);
      chk("x3_data1", 32'(d3_alu_data1), 32'd10);
      chk("x3_data2", 32'(d3_alu_data2), 32'd20);
      chk("x3_no_done", 32'(d3_done0), 32'd0);
      chk("x3_busy", 32'(d3_busy), 32'd1);
      if (k == 1) begin
        r3_req0 = 1'b0;
        r3_a0 = 8'd99;
      end
    end
    @(negedge clk);
    chk("x3_done0", 32'(d3_done0), 32'd1);
    chk("x3_result0", 32'(d3_result0), 32'd30);
    chk("x3_err", 32'(d3_err), 32'd0);
    @(negedge clk);
    chk("x3_done_pulse", 32'(d3_done0), 32'd0);
    chk("x3_idle_busy", 32'(d3_busy), 32'd0);
    chk("x3_idle_sel", 32'(d3_alu_select), 32'd0);

    // Reset mid-EXEC aborts without DONE and clears results
    r3_op0 = 3'b001; r3_a0 = 8'd1; r3_b0 = 8'd2; r3_req0 = 1'b1;
    repeat (2) @(negedge clk);
    chk("x3_exec_before_rst", 32'(d3_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_x3_busy", 32'(d3_busy), 32'd0);
    chk("rst_x3_done", 32'(d3_done0), 32'd0);
    chk("rst_x3_result0", 32'(d3_result0), 32'd0);
    chk("rst_x3_ports", 32'({d3_alu_data1, d3_alu_data2, d3_alu_select}), 32'd0);
    r3_req0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("x3_no_done_after_rst", 32'(d3_done0), 32'd0);
    end

    // Tie after reset: requester 0 first, then 1, and alternation continues
    op0 = 3'b010; a0 = 8'hF0; b0 = 8'h3C;
    op1 = 3'b011; a1 = 8'h0F; b1 = 8'h30;
    req0 = 1'b1; req1 = 1'b1;
    push(1'b0, 8'h30, 1'b0, 3'b010, 2);
    push(1'b1, 8'h3F, 1'b0, 3'b011, 3);
    wait_done();
    wait_done();
    op0 = 3'b001; a0 = 8'h11; b0 = 8'h22;
    op1 = 3'b010; a1 = 8'hFF; b1 = 8'h0F;
    req0 = 1'b1; req1 = 1'b1;
    push(1'b0, 8'h33, 1'b0, 3'b001, 3);
    push(1'b1, 8'h0F, 1'b0, 3'b010, 3);
    wait_done();
    wait_done();

    // Single requests: ADD, FORWARD, wrapping ADD, illegal selects
    single(1'b0, 3'b001, 8'd5,  8'd3,  8'd8,  1'b0);
    single(1'b1, 3'b000, 8'hAA, 8'h55, 8'h55, 1'b0);
    single(1'b0, 3'b001, 8'hFF, 8'h02, 8'h01, 1'b0);
    single(1'b0, 3'b101, 8'h12, 8'h34, 8'h00, 1'b1);
    single(1'b1, 3'b111, 8'h56, 8'h78, 8'h00, 1'b1);
    @(negedge clk);
    chk("final_idle", 32'(busy), 32'd0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 8-bit ALU (FORWARD/ADD/AND/OR, 3-bit select) between two requesters, e.g. the instruction datapath and a debug/DMA port.
- Round-robin arbitration with a REQ/DONE handshake.
- Latches the winner's operands, holds the ALU inputs stable for a programmable number of cycles, then captures the result into that requester's result register.
- Sits between the requesters and the combinational ALU instance.

Parameters:
- DATA_WIDTH, 8, operand/result width.
- SEL_WIDTH, 3, ALU select width.
- EXEC_CYCLES, 1, cycles ALU inputs are held before the result is sampled (legal range 1..15).

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- REQ0  in  1  requester 0 request; level, held until DONE0.
- OP0  in  SEL_WIDTH  requester 0 ALU select.
- A0  in  DATA_WIDTH  requester 0 operand DATA1.
- B0  in  DATA_WIDTH  requester 0 operand DATA2.
- DONE0  out  1  one-cycle pulse: requester 0 result valid.
- RESULT0  out  DATA_WIDTH  requester 0 result register.
- REQ1, OP1, A1, B1, DONE1, RESULT1: as above for requester 1.
- ALU_DATA1  out  DATA_WIDTH  to ALU DATA1.
- ALU_DATA2  out  DATA_WIDTH  to ALU DATA2.
- ALU_SELECT  out  SEL_WIDTH  to ALU SELECT.
- ALU_RESULT  in  DATA_WIDTH  from ALU RESULT.
- BUSY  out  1  high in EXEC and DONE states.
- ERR  out  1  one-cycle pulse with DONEx when the op was illegal.

Behaviour:
- Reset (RESET low, async):
  - state=IDLE, LAST=1 (requester 0 wins first tie).
  - All outputs 0; RESULT0/RESULT1=0.
  - An in-flight op is aborted with no DONE.
- States: IDLE, EXEC, DONE.
- IDLE:
  - ALU_DATA1/ALU_DATA2/ALU_SELECT=0.
  - If exactly one REQx is high, grant x. If both are high, grant the one that is not LAST.
  - On grant: latch OPx/Ax/Bx and GID=x.
  - If the latched op is legal (OPx[2]==0): CNT=EXEC_CYCLES-1, go to EXEC.
  - If illegal (select 1xx): skip the ALU, set RESULTx=0, go to DONE with the error flag set.
- EXEC:
  - Drive ALU ports from the latched registers (stable for the whole state).
  - If CNT!=0, decrement.
  - If CNT==0, RESULT[GID] <= ALU_RESULT; go to DONE.
- DONE:
  - DONE[GID]=1 for exactly this cycle; ERR=1 if flagged.
  - LAST<=GID; go to IDLE.
  - ALU ports keep their latched values.
- Latency: REQ sampled in IDLE at edge t → DONE high in cycle t+EXEC_CYCLES+1 → next grant possible at edge t+EXEC_CYCLES+2.
- Illegal op: DONE in cycle t+1.
- Handshake rules:
  - A requester deasserts REQ in the DONE cycle.
  - REQ still high in the following IDLE is a new request.
  - REQ/OP/A/B changes after the grant are ignored.
  - REQ dropped during EXEC does not cancel; DONE is still pulsed.
- RESULTx holds until that requester's next completion; the other requester's completion never alters it.
- Arithmetic is performed by the ALU only: ADD wraps modulo 2^DATA_WIDTH, no carry reported.
- Never more than one DONE high per cycle; BUSY==(state!=IDLE).

Decomposition:
- Package alu_ctrl_pkg:
  - Select codes SEL_FORWARD=000, SEL_ADD=001, SEL_AND=010, SEL_OR=011.
  - State encoding IDLE/EXEC/DONE.
  - Default DATA_WIDTH/SEL_WIDTH constants.
- One sub-module, rr_arbiter2: combinational 2-way pick from REQ0, REQ1, LAST → grant valid plus GID.
- FSM, counter and registers live in alu_arbiter.

Test Plan:
- REQ0, OP0=001, A0=5, B0=3, EXEC_CYCLES=1 → DONE0 pulses 2 cycles after grant edge; RESULT0=8; RESULT1 stays 0; ERR=0.
- REQ0 and REQ1 both held (OP0=010 A0=0xF0 B0=0x3C; OP1=011 A1=0x0F B1=0x30) → requester 0 serviced first, RESULT0=0x30; then requester 1, RESULT1=0x3F; alternation continues.
- OP1=000, A1=0xAA, B1=0x55 → RESULT1=0x55; OP0=001, A0=0xFF, B0=0x02 → RESULT0=0x01 (wrap).
- OP0=101 → no ALU drive (ALU_SELECT stays 0), DONE0 and ERR pulse 1 cycle after grant, RESULT0=0.
- EXEC_CYCLES=3, ADD 10+20 → ALU ports stable for 3 cycles, DONE0 in cycle grant+4, RESULT0=30; REQ0 dropped mid-EXEC still yields DONE0.
- RESET low during EXEC → immediately IDLE, BUSY=0, no DONE, RESULT0/RESULT1=0, LAST=1; after release, simultaneous requests grant requester 0 first.
